// File: rtl/ring_sampler_pkg.sv
// Shared constants and helpers for the ring-oscillator entropy sampler.
package ring_sampler_pkg;

  localparam int WORD_W         = 32;
  localparam int DEF_REP_LIMIT  = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // Level counter must be able to represent a completely full FIFO.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_sampler_fifo.sv
// First-word fall-through word FIFO; a push on full without a pop is dropped and reported.
module ring_sampler_fifo
  import ring_sampler_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W = level_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              drop_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full, do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/ring_entropy_sampler.sv
// Synchronises and XORs ring-oscillator clocks into 32-bit entropy words with a repetition health test.
// Optional Von Neumann debiasing of the packed bit stream: define RING_SAMPLER_VN_EN.
module ring_entropy_sampler
  import ring_sampler_pkg::*;
#(
  parameter int NUM_RINGS  = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REP_LIMIT  = DEF_REP_LIMIT,
  parameter int DIV_W      = 16
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           enable_i,
  input  logic [NUM_RINGS-1:0]           ring_clk_i,
  input  logic [DIV_W-1:0]               sample_div_i,
  input  logic                           clear_i,
  input  logic                           rd_ready_i,
  output logic                           rd_valid_o,
  output logic [WORD_W-1:0]              rd_data_o,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level_o,
  output logic                           overflow_o,
  output logic                           health_fail_o
);

  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [NUM_RINGS-1:0] sync1_q, sync2_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic                 prev_q, prev_d;
  logic [WORD_W-1:0]    word_q, word_d, push_word;
  logic [5:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d, hf_q, hf_d;
  logic                 tick, raw_bit, bit_vld, bit_val, push, drop, empty, health_set;

  // Read port: rd_valid_o/rd_ready_i, a word transfers on the cycle both are high.
  assign rd_valid_o    = ~empty;
  assign overflow_o    = ovf_q;
  assign health_fail_o = hf_q;

  // ">=" lets a freshly lowered divisor tick and wrap on the next cycle.
  assign tick    = enable_i & (div_q >= sample_div_i);
  assign raw_bit = ^sync2_q;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (!enable_i || tick) div_d = '0;
  end

  always_comb begin
    rep_d  = rep_q;
    prev_d = prev_q;
    if (!enable_i) begin
      rep_d = '0;
    end else if (tick) begin
      prev_d = raw_bit;
      if (rep_q != '0 && raw_bit == prev_q) begin
        if (rep_q != REP_W'(REP_LIMIT)) rep_d = rep_q + REP_W'(1);
      end else begin
        rep_d = REP_W'(1);
      end
    end
    health_set = tick && (rep_d == REP_W'(REP_LIMIT));
  end

`ifdef RING_SAMPLER_VN_EN
  logic vn_have_q, vn_have_d, vn_a_q, vn_a_d;

  always_comb begin
    vn_have_d = vn_have_q;
    vn_a_d    = vn_a_q;
    bit_vld   = 1'b0;
    bit_val   = vn_a_q;
    if (!enable_i) begin
      vn_have_d = 1'b0;
    end else if (tick) begin
      if (!vn_have_q) begin
        vn_have_d = 1'b1;
        vn_a_d    = raw_bit;
      end else begin
        vn_have_d = 1'b0;
        bit_vld   = (vn_a_q != raw_bit);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vn_have_q <= 1'b0;
      vn_a_q    <= 1'b0;
    end else begin
      vn_have_q <= vn_have_d;
      vn_a_q    <= vn_a_d;
    end
  end
`else
  assign bit_vld = tick;
  assign bit_val = raw_bit;
`endif

  // The 32nd bit goes straight to the FIFO instead of landing in word_q.
  assign push_word = {word_q[WORD_W-2:0], bit_val};

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    if (!enable_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (bit_vld) begin
      if (cnt_q == 6'(WORD_W - 1)) begin
        push   = 1'b1;
        word_d = '0;
        cnt_d  = '0;
      end else begin
        word_d = push_word;
        cnt_d  = cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    ovf_d = clear_i ? 1'b0 : ovf_q;
    hf_d  = clear_i ? 1'b0 : hf_q;
    if (drop)       ovf_d = 1'b1;
    if (health_set) hf_d  = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      rep_q   <= '0;
      prev_q  <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hf_q    <= 1'b0;
    end else begin
      sync1_q <= ring_clk_i;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hf_q    <= hf_d;
    end
  end

  ring_sampler_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_ni),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (rd_ready_i),
    .head_o      (rd_data_o),
    .empty_o     (empty),
    .level_o     (fifo_level_o),
    .drop_o      (drop)
  );

endmodule

// File: tb/tb_ring_entropy_sampler.sv
// Bench for ring_entropy_sampler: directed vector table, hand sequences and a randomized run against a reference model.
module tb_ring_entropy_sampler;

  localparam int NR    = 8;
  localparam int DEPTH = 4;
  localparam int REPL  = 32;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset block
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [NR-1:0] ring = '0;
  logic [DW-1:0] div = '0;
  logic          rd_valid, ovf, hf;
  logic [31:0]   rd_data;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  ring_entropy_sampler #(
    .NUM_RINGS (NR), .FIFO_DEPTH (DEPTH), .REP_LIMIT (REPL), .DIV_W (DW)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .enable_i      (en),
    .ring_clk_i    (ring),
    .sample_div_i  (div),
    .clear_i       (clr),
    .rd_ready_i    (rdy),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .fifo_level_o  (level),
    .overflow_o    (ovf),
    .health_fail_o (hf)
  );

  int checks = 0;
  int errors = 0;

  // reference model: expected word queue plus behavioural state
  logic [31:0]   exp_q[$];
  logic [NR-1:0] ring_hist[$];
  bit            bits_q[$];
  int            en_cnt, run_len;
  bit            prev_bit, ovf_m, hf_m, vn_have, vn_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bits_q.delete();
    ring_hist.delete();
    ring_hist.push_back('0);
    ring_hist.push_back('0);
    en_cnt = 0; run_len = 0; prev_bit = 0;
    ovf_m = 0; hf_m = 0; vn_have = 0; vn_a = 0;
  endtask

  // Called right after each rising edge with the inputs that edge saw.
  task automatic model_edge();
    bit raw, tick, pop, pushw, hset, oset;
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw = ^ring_hist[0];
    ring_hist.push_back(ring);
    void'(ring_hist.pop_front());
    pop = rdy && (exp_q.size() > 0);
    pushw = 0; hset = 0; oset = 0; w = '0;
    if (!en) begin
      en_cnt = 0; run_len = 0; vn_have = 0;
      bits_q.delete();
    end else begin
      tick = (en_cnt % (int'(div) + 1)) == int'(div);
      en_cnt++;
      if (tick) begin
        if (run_len > 0 && raw == prev_bit) begin
          if (run_len < REPL) run_len++;
        end else run_len = 1;
        prev_bit = raw;
        if (run_len >= REPL) hset = 1;
`ifdef RING_SAMPLER_VN_EN
        if (!vn_have) begin vn_have = 1; vn_a = raw; end
        else begin
          vn_have = 0;
          if (vn_a != raw) bits_q.push_back(vn_a);
        end
`else
        bits_q.push_back(raw);
`endif
        if (bits_q.size() == 32) begin
          foreach (bits_q[i]) w = {w[30:0], bits_q[i]};
          bits_q.delete();
          pushw = 1;
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (pushw) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else oset = 1;
    end
    ovf_m = oset ? 1'b1 : (clr ? 1'b0 : ovf_m);
    hf_m  = hset ? 1'b1 : (clr ? 1'b0 : hf_m);
  endtask

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
    chk("rd_data", rd_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("fifo_level", 32'(level), 32'(exp_q.size()));
    chk("overflow", 32'(ovf), 32'(ovf_m));
    chk("health_fail", 32'(hf), 32'(hf_m));
  endtask

  // driver: one clock cycle, model update, compare on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input bit check_async);
    rst_n = 1'b0;
    #1;
    if (check_async) begin
      chk("rst_async_valid", 32'(rd_valid), 32'h0);
      chk("rst_async_data", rd_data, 32'h0);
      chk("rst_async_level", 32'(level), 32'h0);
      chk("rst_async_ovf", 32'(ovf), 32'h0);
      chk("rst_async_hf", 32'(hf), 32'h0);
    end
    model_reset();
    en = 0; rdy = 0; clr = 0; ring = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0]   pattern;
    logic [NR-1:0] mask;
    logic [DW-1:0] div;
    logic [31:0]   exp_word;
  } vec_t;

  vec_t        vt[6];
  logic [31:0] ow[6];
  bit          vn_seq[8];
  int          lat;
  bit          seen, b;

  initial begin
    vt[0] = '{32'hA5A5A5A5, 8'h01, 16'd0, 32'hA5A5A5A5};
    vt[1] = '{32'h12345678, 8'h07, 16'd1, 32'h12345678};
    vt[2] = '{32'hC3C3C3C3, 8'h03, 16'd0, 32'h00000000};
    vt[3] = '{32'h0F0F00FF, 8'h80, 16'd3, 32'h0F0F00FF};
    vt[4] = '{32'hFFFFFFFE, 8'hFF, 16'd2, 32'h00000000};
    vt[5] = '{32'h6DB6DB6D, 8'h1F, 16'd0, 32'h6DB6DB6D};
    ow    = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 32'h0BADF00D, 32'hCAFEBABE};
    vn_seq = '{0, 1, 1, 0, 0, 0, 1, 1};

    model_reset();
    do_reset(1'b1);

`ifndef RING_SAMPLER_VN_EN
    // Ring data leads enable by two cycles so tick i samples pattern bit i.
    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      div = vt[v].div;
      lat = 0; seen = 0;
      for (int k = 0; k < 32 * (int'(vt[v].div) + 1) + 40 && !seen; k++) begin
        int idx;
        idx  = k / (int'(div) + 1);
        b    = (idx < 32) ? vt[v].pattern[31 - idx] : 1'b0;
        ring = b ? vt[v].mask : '0;
        en   = (k >= 2);
        step();
        if (en) lat++;
        if (rd_valid) seen = 1;
      end
      chk("tbl_latency", 32'(lat), 32'(32 * (int'(vt[v].div) + 1)));
      chk("tbl_data", rd_data, vt[v].exp_word);
      chk("tbl_level", 32'(level), 32'd1);
      en = 0; rdy = 1;
      step();
      rdy = 0;
    end

    // Overflow, pop-while-full, then reset with two words held mid-word.
    do_reset(1'b0);
    div = 0;
    for (int k = 0; k < 206; k++) begin
      ring = (k < 192) ? {{(NR-1){1'b0}}, ow[k / 32][31 - (k % 32)]} : '0;
      en   = (k >= 2);
      clr  = (k == 170);
      rdy  = (k == 193) || (k == 194) || (k == 195);
      step();
      if (k == 161) begin
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_head", rd_data, ow[0]);
      end
      if (k == 193) begin
        chk("popfull_level", 32'(level), 32'd4);
        chk("popfull_flag", 32'(ovf), 32'd0);
        chk("popfull_head", rd_data, ow[1]);
      end
    end
    rdy = 0; clr = 0;
    chk("pre_rst_level", 32'(level), 32'd2);
    do_reset(1'b1);
    en = 1; lat = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      ring = NR'($urandom);
      step();
      lat++;
      if (rd_valid) seen = 1;
    end
    chk("post_rst_latency", 32'(lat), 32'd32);
`else
    // Raw pairs 01,10,00,11 emit 0,1 per eight raw bits.
    do_reset(1'b0);
    div = 0; lat = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      ring = {{(NR-1){1'b0}}, vn_seq[k % 8]};
      en   = (k >= 2);
      step();
      if (en) lat++;
      if (rd_valid) seen = 1;
    end
    chk("vn_latency", 32'(lat), 32'd128);
    chk("vn_data", rd_data, 32'h55555555);
`endif

    // Health: stuck-zero rings with a tick every other cycle; clear on a non-tick cycle.
    do_reset(1'b0);
    div = 1; ring = '0; en = 1;
    for (int k = 0; k < 63; k++) step();
    chk("hf_before_trip", 32'(hf), 32'd0);
    step();
    chk("hf_trip", 32'(hf), 32'd1);
    clr = 1;
    step();
    clr = 0;
    chk("hf_cleared", 32'(hf), 32'd0);
    step();
    chk("hf_retrip", 32'(hf), 32'd1);

    // Randomized run: free data, starved reader, then near-constant rings.
    do_reset(1'b0);
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        if (ph != 2 || $urandom_range(0, 63) == 0) ring = NR'($urandom);
        rdy = (ph == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
        clr = ($urandom_range(0, 40) == 0);
        if (en && $urandom_range(0, 299) == 0) en = 0;
        else if (!en && $urandom_range(0, 3) == 0) begin
          div = DW'($urandom_range(0, 2));
          en  = 1;
        end
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_entropy_sampler.md
Name: ring_entropy_sampler

Overview:
Consumer of the free-running ring-oscillator outputs (collapsering/ringosc macros) inside digitalcore.
- Synchronises up to NUM_RINGS asynchronous ring clocks into the wb_clk_i domain.
- XOR-combines them into one raw bit per sample tick, packs bits into 32-bit words and buffers them in a small FIFO.
- The Wishbone register file reads the words through a valid/ready port.
- A repetition-count health test flags stuck entropy.

Parameters:
NUM_RINGS, 8, number of ring clock inputs XOR-combined
FIFO_DEPTH, 4, words buffered (power of two, >=2)
REP_LIMIT, 32, consecutive identical raw samples that trip the health flag
DIV_W, 16, width of sample divider

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  sampling enable
ring_clk_i  in  NUM_RINGS  asynchronous ring oscillator outputs
sample_div_i  in  DIV_W  sample tick every sample_div_i+1 cycles
clear_i  in  1  one-cycle pulse; clears overflow_o and health_fail_o
rd_ready_i  in  1  consumer accepts head word
rd_valid_o  out  1  FIFO non-empty
rd_data_o  out  32  FIFO head word (first-word fall-through)
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words held
overflow_o  out  1  sticky: completed word dropped on full FIFO
health_fail_o  out  1  sticky: repetition-count test tripped

Behaviour:
- Reset state: wb_clk_i and wb_rst_ni as decided (one clock; reset asynchronous, active-low). All flops clear. Outputs at reset: rd_valid_o=0, rd_data_o=0, fifo_level_o=0, overflow_o=0, health_fail_o=0.
- Synchroniser: two-flop per ring bit, no reset dependence on ring activity. Sample latency is 2 cycles from ring_clk_i to the sync stage-2 value.
- Divider: counter runs 0..sample_div_i while enable_i=1. Tick when count==sample_div_i, then wrap to 0. sample_div_i=0 gives a tick every cycle. If the count exceeds a newly lowered sample_div_i, tick and wrap next cycle.
- Raw bit: XOR of all stage-2 sync bits, taken on the tick.
- Packing: word <= {word[30:0], bit}, with a 6-bit bit counter. The 32nd bit completes the word, which pushes into the FIFO in the same cycle the bit lands. The counter returns to 0.
- enable_i=0:
  - divider, bit counter, partial word and repetition counter clear;
  - FIFO contents and sticky flags are retained;
  - reading continues.
- FIFO:
  - push on word completion; pop on rd_valid_o & rd_ready_i;
  - push when full with a simultaneous pop is accepted;
  - push when full without a pop drops the new word, keeps the old contents and sets overflow_o;
  - pop when empty is ignored;
  - pointers wrap modulo FIFO_DEPTH.
- Health:
  - the repetition counter compares each raw bit to the previous raw bit (before any debiasing);
  - equal bits increment the counter, saturating; a differing bit resets it to 1;
  - the counter reaching REP_LIMIT sets health_fail_o;
  - sampling continues after a trip.
- clear_i clears both sticky flags. If clear_i and a set event occur in the same cycle, the set wins.
- A mid-operation reset discards everything; no partial word survives.

Optional Feature:
RING_SAMPLER_VN_EN
- Defined: a Von Neumann debiaser sits between the raw bit and the packer. Raw bits are consumed in pairs (a, b):
  - a!=b emits a;
  - a==b emits nothing;
  - the pair state clears when enable_i=0.
  - Word throughput becomes data dependent.
- Undefined: every raw bit goes straight to the packer.
- The health test sees raw bits in both builds.

Decomposition:
- Package ring_sampler_pkg: WORD_W=32, default REP_LIMIT, default FIFO_DEPTH, level-width function.
- One sub-module: ring_sampler_fifo, a synchronous FWFT FIFO with push/pop/full/empty/level and drop-on-full.
- Synchroniser, divider, packer and health test stay in the top module.

Test Plan:
- Reset check: assert wb_rst_ni=0 mid-word with the FIFO holding 2 words -> all outputs 0 immediately; after release, the first word needs a full 32 fresh ticks.
- Packing: sample_div_i=0, bench drives ring_clk_i[0] synchronously with 0xA5A5A5A5 MSB-first, other rings 0 -> rd_valid_o rises, rd_data_o=0xA5A5A5A5, fifo_level_o=1.
- Divider: sample_div_i=3, alternating pattern -> ticks every 4 cycles; first word completes 128 cycles after enable, plus sync latency.
- Overflow: rd_ready_i=0, generate 5 words -> fifo_level_o=4, overflow_o=1, head still word 1. Pop while the 5th word completes -> word accepted, no overflow.
- Health: hold all rings 0 for 32 ticks -> health_fail_o=1 on tick 32. clear_i pulse -> 0; with rings still 0 it re-trips on the next tick.
- VN (RING_SAMPLER_VN_EN defined): raw pairs 01,10,00,11 repeated -> packed bits 0,1 per 8 raw; word 0x55555555 after 128 raw bits.
